// File: rtl/seg7_scan_ctrl_if.sv
// Host update channel for seg7_scan_ctrl.
// Carries a valid/ready handshake and one BCD display word.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    upd_valid;
    logic                    upd_ready;
    logic [4*NUM_DIGITS-1:0] upd_data;

    modport master (
        output upd_valid,
        output upd_data,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_data,
        output upd_ready
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a shared decoder.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    seg7_scan_ctrl_if.slave       upd,
    output logic [3:0]            bcd_out,
    input  logic [6:0]            seg_in,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic                  frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int W     = 4 * NUM_DIGITS;

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    fd_n;
    logic [W-1:0]            disp_reg, disp_n;
    logic [W-1:0]            pend_reg, pend_n;
    logic                    pend_flag, pflag_n;

    logic [3:0]              digits [NUM_DIGITS];
    logic                    blank;
    logic [6:0]              seg_gated;

    assign upd.upd_ready = !pend_flag;

    // Split the shown word into per-digit codes for the scan mux.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digits[k] = disp_reg[4*k +: 4];
        end
    end

    assign bcd_out = digits[idx];

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;

    // Mark digits that are zero along with every digit above them.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (digits[k] == 4'd0);
            lz_mask[k] = zero_above;
        end
    end

    assign blank = (bcd_out > 4'd9) || lz_mask[idx];
`else
    assign blank = (bcd_out > 4'd9);
`endif

    assign seg_gated = blank ? 7'd0 : seg_in;

    // Next-state, scan outputs, handshake capture and frame commit.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        seg_n   = seg_out;
        an_n    = an_out;
        fd_n    = 1'b0;
        disp_n  = disp_reg;
        pend_n  = pend_reg;
        pflag_n = pend_flag;

        if (upd.upd_valid && !pend_flag) begin
            pend_n  = upd.upd_data;
            pflag_n = 1'b1;
        end

        if (!en) begin
            state_n = BLANK;
            idx_n   = '0;
            cnt_n   = '0;
            seg_n   = '0;
            an_n    = '0;
            if (pend_flag) begin
                disp_n  = pend_reg;
                pflag_n = 1'b0;
            end
        end else begin
            unique case (state)
                BLANK: begin
                    if (cnt == CNT_W'(DEAD_CYCLES - 1)) begin
                        seg_n   = seg_gated;
                        an_n    = NUM_DIGITS'(1) << idx;
                        cnt_n   = '0;
                        state_n = SHOW;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                        an_n    = '0;
                        seg_n   = '0;
                        cnt_n   = '0;
                        state_n = BLANK;
                        if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_n = '0;
                            fd_n  = 1'b1;
                            if (pend_flag) begin
                                disp_n  = pend_reg;
                                pflag_n = 1'b0;
                            end
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = BLANK;
                end
            endcase
        end
    end

    // Register all controller state; reset blanks the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            seg_out    <= '0;
            an_out     <= '0;
            frame_done <= 1'b0;
            disp_reg   <= '1;
            pend_reg   <= '0;
            pend_flag  <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            seg_out    <= seg_n;
            an_out     <= an_n;
            frame_done <= fd_n;
            disp_reg   <= disp_n;
            pend_reg   <= pend_n;
            pend_flag  <= pflag_n;
        end
    end

endmodule
